// File: rtl/fic_pkg.sv
// Shared width constants for the fixed-point interface blocks.
// Holds sign-extension widths and narrowing/statistics defaults.
package fic_pkg;

    // Sign-extension widths used by the widening path.
    localparam int SEXT_SRC_W = 8;
    localparam int SEXT_DST_W = 16;

    // Defaults for the narrowing path.
    localparam int DEF_W  = 8;
    localparam int DEF_CW = 8;

endpackage

// File: rtl/saturate_narrow_fifo2.sv
// fifo2: two-entry in-order skid buffer with valid/ready on both sides.
// Ports: clk, rst, in_data/in_valid/in_ready, out_data/out_valid/out_ready.
module fifo2 #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [1:0]    slot;
    logic          push, pop;

    // Ready depends only on the registered occupancy; rst gating keeps
    // it low throughout reset and high right after release.
    assign in_ready  = (cnt_q != 2'd2) && !rst;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;
    // Write position after the (optional) pop has shifted tail to head.
    assign slot = cnt_q - {1'b0, pop};

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        if (pop) begin
            head_d = tail_q;
        end
        if (push) begin
            if (slot == 2'd0) begin
                head_d = in_data;
            end else begin
                tail_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/saturate_narrow.sv
// saturate_narrow: narrows a signed 2W value to W bits (saturate or wrap),
// buffers results in fifo2 and keeps sticky/counted overflow statistics.
// Ports: in_* / out_* valid-ready streams, wrap_mode, clr_stat,
// sticky_ovf, ovf_count.
module saturate_narrow
    import fic_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2*W-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           wrap_mode,
    output logic [W-1:0]   out_data,
    output logic           out_ovf,
    output logic           out_valid,
    input  logic           out_ready,
    input  logic           clr_stat,
    output logic           sticky_ovf,
    output logic [CW-1:0]  ovf_count
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [W:0]   top_bits;
    logic         ovf;
    logic [W-1:0] sat_val;
    logic [W-1:0] nar_val;
    logic [W:0]   buf_in, buf_out;
    logic         accept;

    logic          sticky_q, sticky_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The value fits in W bits only if the sign bit and everything
    // above it are identical.
    assign top_bits = in_data[2*W-1:W-1];
    assign ovf      = !((&top_bits) || !(|top_bits));
    assign sat_val  = in_data[2*W-1] ? {1'b1, {(W-1){1'b0}}}
                                     : {1'b0, {(W-1){1'b1}}};
    assign nar_val  = (ovf && !wrap_mode) ? sat_val : in_data[W-1:0];
    assign buf_in   = {ovf, nar_val};
    assign accept   = in_valid && in_ready;

    fifo2 #(
        .DW(W + 1)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .in_data  (buf_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (buf_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign out_data = buf_out[W-1:0];
    assign out_ovf  = buf_out[W];

    // Clear applies first so a same-cycle overflow still counts once.
    always_comb begin
        sticky_d = clr_stat ? 1'b0 : sticky_q;
        cnt_d    = clr_stat ? '0 : cnt_q;
        if (accept && ovf) begin
            sticky_d = 1'b1;
            if (cnt_d != CNT_MAX) begin
                cnt_d = cnt_d + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sticky_ovf = sticky_q;
    assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_saturate_narrow.sv
// Directed bench for saturate_narrow with a scoreboard queue.
// Stimulus drives at negedge; outputs sampled just after it.
module tb_saturate_narrow;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wrap_mode;
    logic [7:0]  out_data;
    logic        out_ovf;
    logic        out_valid;
    logic        out_ready;
    logic        clr_stat;
    logic        sticky_ovf;
    logic [7:0]  ovf_count;

    int passed = 0;
    int total  = 0;
    logic [8:0] sb[$];
    int  cnt_m = 0;
    bit  sticky_m = 0;

    always #5 clk = ~clk;

    saturate_narrow #(.W(8), .CW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wrap_mode (wrap_mode),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clr_stat  (clr_stat),
        .sticky_ovf(sticky_ovf),
        .ovf_count (ovf_count)
    );

    function automatic logic [8:0] model(logic [15:0] d, logic w);
        int  s;
        bit  o;
        logic [7:0] r;
        s = int'($signed(d));
        o = (s > 127) || (s < -128);
        if (o && !w) r = (s < 0) ? 8'h80 : 8'h7F;
        else         r = d[7:0];
        return {o, r};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        bit acc, del;
        logic [8:0] e;
        #1;
        acc = in_valid && in_ready;
        del = out_valid && out_ready;
        if (del) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e[7:0]));
                chk("out_ovf", 32'(out_ovf), 32'(e[8]));
            end
        end
        e = model(in_data, wrap_mode);
        if (acc) sb.push_back(e);
        if (clr_stat) begin
            cnt_m = 0;
            sticky_m = 0;
        end
        if (acc && e[8]) begin
            sticky_m = 1;
            if (cnt_m != 255) cnt_m++;
        end
        if (rst) begin
            sb.delete();
            cnt_m = 0;
            sticky_m = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(logic [15:0] d, logic w);
        in_data   = d;
        wrap_mode = w;
        in_valid  = 1'b1;
        tick();
        chk("latency_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_stats(string tag);
        chk({tag, "_cnt"}, 32'(ovf_count), 32'(cnt_m));
        chk({tag, "_sticky"}, 32'(sticky_ovf), 32'(sticky_m));
    endtask

    initial begin
        bit got;
        rst = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        wrap_mode = 1'b0;
        out_ready = 1'b0;
        clr_stat = 1'b0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_sticky", 32'(sticky_ovf), 32'd0);
        chk("rst_count", 32'(ovf_count), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // saturate mode
        out_ready = 1'b1;
        send(16'h007F, 1'b0);
        send(16'h0080, 1'b0);
        send(16'hFF80, 1'b0);
        send(16'hFF7F, 1'b0);
        drain();
        chk("sat_count", 32'(ovf_count), 32'd2);
        chk("sat_sticky", 32'(sticky_ovf), 32'd1);

        // wrap mode
        send(16'h0180, 1'b1);
        send(16'hFFFF, 1'b1);
        drain();
        chk_stats("wrap");

        // backpressure
        out_ready = 1'b0;
        send(16'h0001, 1'b0);
        in_data = 16'h0002;
        tick();
        in_data = 16'h0003;
        chk("bp_full", 32'(in_ready), 32'd0);
        tick();
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_data", 32'(out_data), 32'h01);
        chk("bp_queued", 32'(sb.size()), 32'd2);
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            got = in_ready;
            tick();
        end
        chk("bp_accept3", 32'(got), 32'd1);
        drain();

        // statistics saturation
        in_valid = 1'b1;
        in_data = 16'h1000;
        wrap_mode = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        drain();
        chk("stat_sat", 32'(ovf_count), 32'd255);
        chk_stats("stat");
        clr_stat = 1'b1;
        in_valid = 1'b1;
        in_data = 16'h8000;
        tick();
        clr_stat = 1'b0;
        in_valid = 1'b0;
        chk("clr_ovf_cnt", 32'(ovf_count), 32'd1);
        chk("clr_ovf_sticky", 32'(sticky_ovf), 32'd1);
        drain();
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        chk_stats("clr_only");
        chk("clr_only_zero", 32'(ovf_count), 32'd0);

        // reset with buffered beats
        out_ready = 1'b0;
        send(16'h0200, 1'b0);
        in_data = 16'h0042;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(ovf_count), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready_after", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_stale_out", 32'(out_valid), 32'd0);
        end
        chk("sb_final", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/saturate_narrow.md
SATURATE_NARROW -- requirements
Module: saturate_narrow

Interface
REQ-001 SHALL have parameter W, default 8, giving the output data width; the input width is 2*W.
REQ-002 SHALL have parameter CW, default 8, giving the overflow-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_data, input, 2*W, signed two's-complement wide value.
REQ-006 SHALL have port in_valid, input, 1, in_data is valid.
REQ-007 SHALL have port in_ready, output, 1, the block accepts a beat this cycle.
REQ-008 SHALL have port wrap_mode, input, 1, sampled with each accepted beat: 0 = saturate, 1 = truncate/wrap.
REQ-009 SHALL have port out_data, output, W, the narrowed signed result.
REQ-010 SHALL have port out_ovf, output, 1, per-beat overflow flag aligned with out_data.
REQ-011 SHALL have port out_valid, output, 1, out_data and out_ovf are valid.
REQ-012 SHALL have port out_ready, input, 1, the consumer accepts a beat.
REQ-013 SHALL have port clr_stat, input, 1, clears sticky_ovf and ovf_count.
REQ-014 SHALL have port sticky_ovf, output, 1, set when any accepted beat overflowed.
REQ-015 SHALL have port ovf_count, output, CW, number of overflowed beats accepted.

Function
REQ-016 SHALL accept a beat when in_valid && in_ready, and deliver a beat when out_valid && out_ready.
REQ-017 SHALL flag a beat as overflowed if in_data[2W-1:W-1] are not all equal.
REQ-018 SHALL, in saturate mode with overflow, output 0 followed by W-1 ones if in_data[2W-1]=0, else 1 followed by W-1 zeros.
REQ-019 SHALL, in wrap mode or when there is no overflow, output in_data[W-1:0].
REQ-020 SHALL hold results in a 2-entry FIFO buffer; in_ready = (occupancy < 2), a registered function of the occupancy with no combinational path from out_ready.
REQ-021 SHALL have a latency of 1 cycle: a beat accepted at edge N is visible with out_valid=1 after edge N.
REQ-022 SHALL deliver beats in acceptance order, with no loss or duplication under arbitrary out_ready.
REQ-023 SHALL, on simultaneous accept and deliver, keep occupancy unchanged; at full, accept is impossible because in_ready=0.
REQ-024 SHALL hold out_data and out_ovf stable while out_valid=1 and out_ready=0.
REQ-025 SHALL set sticky_ovf and increment ovf_count by one on each accepted overflowed beat; ovf_count saturates at 2^CW-1 and does not wrap.
REQ-026 SHALL let clr_stat zero both statistics; if an overflowed beat is accepted in the same cycle, the result is sticky_ovf=1, ovf_count=1.

Reset
REQ-027 SHALL, while rst=1, force occupancy 0, out_valid=0, in_ready=0, out_data=0, out_ovf=0, sticky_ovf=0, ovf_count=0.
REQ-028 SHALL set in_ready=1 on the first cycle after rst deasserts.
REQ-029 SHALL discard in-flight buffered beats when rst is asserted mid-operation; none are delivered after reset.

Structure
REQ-030 SHALL take the default W and CW values from the shared package fic_pkg, alongside the existing sign-extension width constants.
REQ-031 SHALL place the 2-entry buffer in one sub-module, fifo2, parameterised on data width (W+1, carrying data plus ovf); the narrowing logic stays in the top module.

Verification (W=8, CW=8)
REQ-032 SHALL verify saturate mode, out_ready=1: in 0x007F -> 0x7F ovf=0; 0x0080 -> 0x7F ovf=1; 0xFF80 -> 0x80 ovf=0; 0xFF7F -> 0x80 ovf=1; each one cycle after acceptance; ovf_count=2, sticky_ovf=1.
REQ-033 SHALL verify wrap mode: in 0x0180 -> 0x80 ovf=1; 0xFFFF -> 0xFF ovf=0.
REQ-034 SHALL verify backpressure: out_ready=0 with in_valid=1 for data 0x0001, 0x0002, 0x0003 -> only two accepted, in_ready=0; then out_ready=1 -> 0x01, 0x02, 0x03 delivered in order.
REQ-035 SHALL verify statistics: 300 overflowed beats -> ovf_count=255; clr_stat together with an overflowed beat -> ovf_count=1, sticky_ovf=1.
REQ-036 SHALL verify reset: rst pulsed with 2 beats buffered -> out_valid=0, ovf_count=0; in_ready=1 on the following cycle; the buffered beats never appear.
